microcode_sequencer: RTL and testbench

Parametrised, writable successor to the case-statement microcode ROM. Forms a lookup address from an instruction opcode, ALU flags and an internal phase counter. Matches that address against a table of programmable match/care entries, like a run-time loadable casez. Registers the winning control word and sits between instruction fetch and the datapath control lines of the lab CPU.

---
 rtl/microcode_sequencer.sv | 110 +++++++++++
 tb/tb_microcode_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/microcode_sequencer.sv
// Writable microcode sequencer: {opcode, flags, phase} is matched against a
// table of match/care entries; the lowest-index hit is registered as ctrl_word.
module microcode_sequencer #(
   parameter int             OPW          = 4,
   parameter int             FLW          = 2,
   parameter int             PHW          = 1,
   parameter int             PHASES       = 2,
   parameter int             CWW          = 13,
   parameter int             DEPTH        = 16,
   parameter logic [CWW-1:0] DEFAULT_WORD = '0,
   localparam int            IW           = $clog2(DEPTH),
   localparam int            AW           = OPW + FLW + PHW
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           enable,
   input  logic           phase_clear,
   input  logic [OPW-1:0] opcode,
   input  logic [FLW-1:0] flags,
   input  logic           wr_en,
   input  logic [IW-1:0]  wr_idx,
   input  logic [AW-1:0]  wr_match,
   input  logic [AW-1:0]  wr_care,
   input  logic [CWW-1:0] wr_data,
   input  logic           wr_valid,
   output logic [CWW-1:0] ctrl_word,
   output logic           ctrl_valid,
   output logic           miss,
   output logic [PHW-1:0] phase
);

   logic [AW-1:0]    match_q [DEPTH];
   logic [AW-1:0]    care_q  [DEPTH];
   logic [CWW-1:0]   data_q  [DEPTH];
   logic [DEPTH-1:0] valid_q, valid_d;
   logic [PHW-1:0]   phase_q, phase_d;
   logic [CWW-1:0]   word_q, word_d;
   logic             miss_q, miss_d;
   logic             cvalid_q, cvalid_d;

   logic [AW-1:0]    addr;
   logic [CWW-1:0]   lk_word;
   logic             lk_hit;
   logic             wr_ok;

   assign addr  = {opcode, flags, phase_q};
   assign wr_ok = wr_en && !reset && (int'(wr_idx) < DEPTH);

   // Scan from the highest index down so the lowest-index hit is the last one kept.
   always_comb begin
      lk_word = DEFAULT_WORD;
      lk_hit  = 1'b0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (valid_q[i] && (((addr ^ match_q[i]) & care_q[i]) == '0)) begin
            lk_word = data_q[i];
            lk_hit  = 1'b1;
         end
      end
   end

   always_comb begin
      phase_d  = phase_q;
      word_d   = word_q;
      miss_d   = miss_q;
      cvalid_d = 1'b0;
      valid_d  = valid_q;
      if (phase_clear) begin
         phase_d = '0;
      end else if (enable) begin
         word_d   = lk_word;
         miss_d   = !lk_hit;
         cvalid_d = 1'b1;
         phase_d  = (phase_q == PHW'(PHASES - 1)) ? '0 : phase_q + 1'b1;
      end
      if (wr_ok) begin
         valid_d[wr_idx] = wr_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         phase_q  <= '0;
         word_q   <= '0;
         miss_q   <= 1'b0;
         cvalid_q <= 1'b0;
         valid_q  <= '0;
      end else begin
         phase_q  <= phase_d;
         word_q   <= word_d;
         miss_q   <= miss_d;
         cvalid_q <= cvalid_d;
         valid_q  <= valid_d;
      end
   end

   // Pattern storage is never cleared; an entry is only live while its valid bit is set.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         match_q[wr_idx] <= wr_match;
         care_q[wr_idx]  <= wr_care;
         data_q[wr_idx]  <= wr_data;
      end
   end

   assign ctrl_word  = word_q;
   assign ctrl_valid = cvalid_q;
   assign miss       = miss_q;
   assign phase      = phase_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Bench for microcode_sequencer: directed scenarios plus randomized traffic
// checked against a first-match table model.
module tb_microcode_sequencer;
   localparam int OPW = 4, FLW = 2, PHW = 1, PHASES = 2, CWW = 13, DEPTH = 16;
   localparam int IW = 4, AW = 7;

   logic           clk = 1'b0;
   logic           reset = 1'b1, enable = 1'b0, phase_clear = 1'b0;
   logic [OPW-1:0] opcode = '0;
   logic [FLW-1:0] flags = '0;
   logic           wr_en = 1'b0, wr_valid = 1'b0;
   logic [IW-1:0]  wr_idx = '0;
   logic [AW-1:0]  wr_match = '0, wr_care = '0;
   logic [CWW-1:0] wr_data = '0;
   logic [CWW-1:0] ctrl_word;
   logic           ctrl_valid, miss;
   logic [PHW-1:0] phase;

   always #5 clk = ~clk;

   microcode_sequencer #(.OPW(OPW), .FLW(FLW), .PHW(PHW), .PHASES(PHASES), .CWW(CWW),
                         .DEPTH(DEPTH), .DEFAULT_WORD('0)) dut (
      .clk(clk), .reset(reset), .enable(enable), .phase_clear(phase_clear),
      .opcode(opcode), .flags(flags), .wr_en(wr_en), .wr_idx(wr_idx),
      .wr_match(wr_match), .wr_care(wr_care), .wr_data(wr_data), .wr_valid(wr_valid),
      .ctrl_word(ctrl_word), .ctrl_valid(ctrl_valid), .miss(miss), .phase(phase));

   // Reference model: an ordered list of entries, first live match wins.
   logic [AW-1:0]  m_match [DEPTH];
   logic [AW-1:0]  m_care  [DEPTH];
   logic [CWW-1:0] m_data  [DEPTH];
   bit             m_live  [DEPTH];
   logic [CWW-1:0] m_word = '0;
   bit             m_miss = 1'b0, m_valid = 1'b0;
   int             m_phase = 0;
   int             vectors = 0, miscompares = 0;

   task automatic step();
      logic [AW-1:0]  a;
      logic [CWW-1:0] w;
      bit             hit;
      if (reset) begin
         m_phase = 0; m_word = '0; m_miss = 1'b0; m_valid = 1'b0;
         foreach (m_live[i]) m_live[i] = 1'b0;
      end else begin
         if (phase_clear) begin
            m_phase = 0; m_valid = 1'b0;
         end else if (enable) begin
            a = {opcode, flags, PHW'(m_phase)};
            w = '0; hit = 1'b0;
            for (int i = 0; i < DEPTH; i++)
               if (!hit && m_live[i] && (((a ^ m_match[i]) & m_care[i]) == '0)) begin
                  hit = 1'b1; w = m_data[i];
               end
            m_word = w; m_miss = !hit; m_valid = 1'b1;
            m_phase = (m_phase + 1) % PHASES;
         end else begin
            m_valid = 1'b0;
         end
         if (wr_en && int'(wr_idx) < DEPTH) begin
            m_match[wr_idx] = wr_match; m_care[wr_idx] = wr_care;
            m_data[wr_idx] = wr_data; m_live[wr_idx] = wr_valid;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic write_entry(input int idx, input logic [AW-1:0] mt, input logic [AW-1:0] cr,
                              input logic [CWW-1:0] d, input bit v);
      enable = 1'b0; phase_clear = 1'b0;
      wr_en = 1'b1; wr_idx = IW'(idx); wr_match = mt; wr_care = cr; wr_data = d; wr_valid = v;
      step();
      wr_en = 1'b0;
   endtask

   // Leaves the counter at phase 1 by clearing, then doing one enabled lookup.
   task automatic to_phase1();
      enable = 1'b0; phase_clear = 1'b1; step();
      phase_clear = 1'b0; enable = 1'b1; step();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      wr_en = 1'b1; wr_idx = '0; wr_match = '0; wr_care = '0; wr_data = 13'h0777; wr_valid = 1'b1;
      step(); step();
      reset = 1'b0; wr_en = 1'b0;
      vectors++;
      if ({ctrl_word, ctrl_valid, miss, phase} !== {13'h0, 1'b0, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_state: word=%h vld=%b miss=%b ph=%b want 0000 0 0 0", ctrl_word, ctrl_valid, miss, phase);
      end
      enable = 1'b1; opcode = 4'b0000; flags = 2'b00;
      step();
      vectors++;
      if ({ctrl_word, ctrl_valid, miss, phase} !== {13'h0, 1'b1, 1'b1, 1'b1}) begin
         miscompares++;
         $display("FAIL reset_first_lookup: word=%h vld=%b miss=%b ph=%b want 0000 1 1 1", ctrl_word, ctrl_valid, miss, phase);
      end
      step();
      vectors++;
      if ({ctrl_valid, miss, phase} !== {1'b1, 1'b1, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_phase_wrap: vld=%b miss=%b ph=%b want 1 1 0", ctrl_valid, miss, phase);
      end
   endtask

   task automatic test_fetch();
      write_entry(15, 7'b0000000, 7'b0000001, 13'b1000000001000, 1'b1);
      for (int k = 0; k < 4; k++) begin
         enable = 1'b0; phase_clear = 1'b1; step();
         phase_clear = 1'b0; enable = 1'b1; opcode = 4'b0101; flags = 2'(k);
         step();
         vectors++;
         if ({ctrl_word, miss, ctrl_valid} !== {13'b1000000001000, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL fetch flags=%0d: word=%h miss=%b vld=%b want 1008 0 1", k, ctrl_word, miss, ctrl_valid);
         end
      end
   endtask

   task automatic test_priority();
      write_entry(2, 7'b0110001, 7'b1111001, 13'h0A5, 1'b1);
      write_entry(5, 7'b0110001, 7'b1111111, 13'h1F0, 1'b1);
      opcode = 4'b0110; flags = 2'b00;
      to_phase1(); step();
      vectors++;
      if (ctrl_word !== 13'h0A5 || miss !== 1'b0) begin
         miscompares++;
         $display("FAIL priority_low_index: word=%h miss=%b want 0a5 0", ctrl_word, miss);
      end
      write_entry(2, 7'b0110001, 7'b1111001, 13'h0A5, 1'b0);
      opcode = 4'b0110; flags = 2'b00;
      to_phase1(); step();
      vectors++;
      if (ctrl_word !== 13'h1F0 || miss !== 1'b0) begin
         miscompares++;
         $display("FAIL priority_after_delete: word=%h miss=%b want 1f0 0", ctrl_word, miss);
      end
   endtask

   task automatic test_flag_branch();
      logic [CWW-1:0] exp;
      write_entry(3, 7'b1000011, 7'b1111011, 13'h055, 1'b1);
      write_entry(4, 7'b1000001, 7'b1111011, 13'h0AA, 1'b1);
      for (int k = 0; k < 4; k++) begin
         opcode = 4'b1000; flags = 2'(k);
         to_phase1(); step();
         exp = flags[0] ? 13'h055 : 13'h0AA;
         vectors++;
         if (ctrl_word !== exp || miss !== 1'b0) begin
            miscompares++;
            $display("FAIL flag_branch flags=%b: word=%h miss=%b want %h 0", flags, ctrl_word, miss, exp);
         end
      end
   endtask

   task automatic test_same_cycle_write();
      opcode = 4'($urandom_range(0, 15)); flags = 2'($urandom);
      enable = 1'b0; phase_clear = 1'b1; step();
      phase_clear = 1'b0; enable = 1'b1;
      wr_en = 1'b1; wr_idx = '0; wr_match = {opcode, flags, 1'b0}; wr_care = '1;
      wr_data = 13'h1234; wr_valid = 1'b1;
      step();
      wr_en = 1'b0;
      vectors++;
      if (ctrl_word !== 13'h1008 || miss !== 1'b0) begin
         miscompares++;
         $display("FAIL same_cycle_old: word=%h miss=%b want 1008 0", ctrl_word, miss);
      end
      enable = 1'b0; phase_clear = 1'b1; step();
      phase_clear = 1'b0; enable = 1'b1; step();
      vectors++;
      if (ctrl_word !== 13'h1234 || miss !== 1'b0) begin
         miscompares++;
         $display("FAIL same_cycle_new: word=%h miss=%b want 1234 0", ctrl_word, miss);
      end
   endtask

   task automatic test_controls();
      logic [CWW-1:0] w;
      logic [PHW-1:0] p;
      enable = 1'b1; opcode = 4'b0101; flags = 2'b10; step();
      w = ctrl_word; p = phase;
      enable = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         vectors++;
         if (ctrl_word !== w || phase !== p || ctrl_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL hold cyc%0d: word=%h ph=%b vld=%b want %h %b 0", k, ctrl_word, phase, ctrl_valid, w, p);
         end
      end
      to_phase1();
      w = ctrl_word;
      phase_clear = 1'b1; enable = 1'b1; step();
      phase_clear = 1'b0;
      vectors++;
      if (phase !== 1'b0 || ctrl_valid !== 1'b0 || ctrl_word !== w) begin
         miscompares++;
         $display("FAIL clear_over_enable: ph=%b vld=%b word=%h want 0 0 %h", phase, ctrl_valid, ctrl_word, w);
      end
      enable = 1'b1; step();
      reset = 1'b1; step();
      reset = 1'b0;
      vectors++;
      if ({ctrl_word, ctrl_valid, miss, phase} !== {13'h0, 1'b0, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL mid_reset: word=%h vld=%b miss=%b ph=%b want 0000 0 0 0", ctrl_word, ctrl_valid, miss, phase);
      end
      opcode = 4'b0101; flags = 2'b00; step();
      vectors++;
      if ({ctrl_word, ctrl_valid, miss} !== {13'h0, 1'b1, 1'b1}) begin
         miscompares++;
         $display("FAIL post_reset_miss: word=%h vld=%b miss=%b want 0000 1 1", ctrl_word, ctrl_valid, miss);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         reset       = ($urandom_range(0, 79) == 0);
         phase_clear = ($urandom_range(0, 7) == 0);
         enable      = ($urandom_range(0, 3) != 0);
         opcode      = 4'($urandom_range(0, 3));
         flags       = 2'($urandom);
         wr_en       = ($urandom_range(0, 2) == 0);
         wr_idx      = IW'($urandom);
         wr_match    = {4'($urandom_range(0, 3)), 3'($urandom)};
         wr_care     = ($urandom_range(0, 5) == 0) ? 7'h00 : 7'($urandom);
         wr_data     = 13'($urandom);
         wr_valid    = ($urandom_range(0, 4) != 0);
         step();
         vectors++;
         if ({ctrl_word, miss, ctrl_valid, phase} !== {m_word, m_miss, m_valid, PHW'(m_phase)}) begin
            miscompares++;
            $display("FAIL random cyc%0d: word=%h miss=%b vld=%b ph=%b want %h %b %b %0d",
                     c, ctrl_word, miss, ctrl_valid, phase, m_word, m_miss, m_valid, m_phase);
         end
      end
      reset = 1'b0; wr_en = 1'b0; enable = 1'b0; phase_clear = 1'b0;
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_priority();
      test_flag_branch();
      test_same_cycle_write();
      test_controls();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
